alu_mdu_ctrl: RTL and testbench

- Parametrised successor to the ALU control unit: the same ALUOp/func3/inst_30/inst_5 decode to ALU_sel/type_IR, extended with RV32M decode (inst_25) and an iterative multiply/divide sequencer.
- Sits in EX beside the ALU; drives a pipeline stall while an M-op is in flight, then presents md_result for one DONE cycle.
- Width is generic (XLEN).

---
 rtl/alu_mdu_ctrl_pkg.sv | 46 ++++
 rtl/alu_mdu_ctrl_mdu_core.sv | 161 ++++++++++++++++
 rtl/alu_mdu_ctrl.sv | 73 +++++++
 tb/tb_alu_mdu_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_ctrl_pkg.sv
// Shared encodings for the ALU control / RV32M sequencer block:
// ALU select codes, operand-type flags, M-extension func3 codes and MDU states.
package alu_mdu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd15;

    localparam logic ITYPE = 1'b0;
    localparam logic RTYPE = 1'b1;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    // rs1 is treated as signed for every op except the fully unsigned ones
    function automatic logic f3_rs1_signed(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    // rs2 is signed only for MUL/MULH/DIV/REM (MULHSU keeps rs2 unsigned)
    function automatic logic f3_rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/alu_mdu_ctrl_mdu_core.sv
// Iterative multiply/divide sequencer: FSM, iteration counter and datapath.
// Operands are latched as magnitudes; sign correction is applied in FIX.
// Optional MDU_FAST_MUL_EN: MUL* ops finish with one combinational multiply.
module mdu_core
    import alu_mdu_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            done_o,
    output logic            in_done_o,
    output logic [XLEN-1:0] result_o
);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   opd_q, opd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;     // {hi, lo}: product or {remainder, quotient}
    logic              neg_lo_q, neg_lo_d; // negate product / quotient
    logic              neg_hi_q, neg_hi_d; // negate remainder
    logic [XLEN-1:0]   result_q, result_d;

    logic              sgn_a, sgn_b, div_zero, div_ovf, last;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
`ifndef MDU_FAST_MUL_EN
    logic [XLEN:0]     mul_sum;
`endif

    // operand preparation and per-step datapath
    always_comb begin
        sgn_a     = f3_rs1_signed(func3_i) & rs1_i[XLEN-1];
        sgn_b     = f3_rs2_signed(func3_i) & rs2_i[XLEN-1];
        a_mag     = sgn_a ? -rs1_i : rs1_i;
        b_mag     = sgn_b ? -rs2_i : rs2_i;
        div_zero  = (rs2_i == '0);
        div_ovf   = ((func3_i == F3_DIV) || (func3_i == F3_REM)) &&
                    (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        last      = (cnt_q == CNT_W'(XLEN-1));
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opd_q};
`ifndef MDU_FAST_MUL_EN
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
`endif
        prod_fix  = neg_lo_q ? -acc_q : acc_q;
        quo_fix   = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    // next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        result_d = result_q;
        if (flush_i && (state_q != MDU_IDLE)) begin
            state_d = MDU_IDLE;
        end else begin
            unique case (state_q)
                MDU_IDLE: if (start_i) begin
                    cnt_d    = '0;
                    f3_d     = func3_i;
                    neg_lo_d = sgn_a ^ sgn_b;
                    state_d  = MDU_CALC;
                    if (func3_i[2]) begin
                        opd_d    = b_mag;
                        acc_d    = {{XLEN{1'b0}}, a_mag};
                        neg_hi_d = sgn_a;
                        // special cases skip the iteration; results are final already
                        if (div_zero) begin
                            acc_d    = {rs1_i, {XLEN{1'b1}}};
                            neg_lo_d = 1'b0;
                            neg_hi_d = 1'b0;
                            state_d  = MDU_FIX;
                        end else if (div_ovf) begin
                            acc_d    = {{XLEN{1'b0}}, rs1_i};
                            neg_lo_d = 1'b0;
                            neg_hi_d = 1'b0;
                            state_d  = MDU_FIX;
                        end
                    end else begin
                        opd_d    = a_mag;
                        acc_d    = {{XLEN{1'b0}}, b_mag};
                        neg_hi_d = 1'b0;
                    end
                end
                MDU_CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (f3_q[2]) begin
                        // restoring division: shift in next dividend bit, subtract if it fits
                        if (!div_trial[XLEN])
                            acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                        else
                            acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                        if (last) state_d = MDU_FIX;
                    end else begin
`ifdef MDU_FAST_MUL_EN
                        acc_d   = {{XLEN{1'b0}}, opd_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
                        state_d = MDU_FIX;
`else
                        // shift-add: conditionally add multiplicand to hi, shift right
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                        if (last) state_d = MDU_FIX;
`endif
                    end
                end
                MDU_FIX: begin
                    unique case (f3_q)
                        F3_MUL:                       result_d = prod_fix[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                        F3_DIV, F3_DIVU:              result_d = quo_fix;
                        default:                      result_d = rem_fix;
                    endcase
                    state_d = MDU_DONE;
                end
                default: state_d = MDU_IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            opd_q    <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            result_q <= result_d;
        end
    end

    assign in_done_o = (state_q == MDU_DONE);
    assign done_o    = in_done_o & ~flush_i;
    assign result_o  = result_q;

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU control decode with RV32M detection plus the multiply/divide sequencer.
// Decode and stall are combinational; the sequencer lives in mdu_core.
// Optional MDU_FAST_MUL_EN (in mdu_core): single-cycle multiply.
module alu_mdu_ctrl
    import alu_mdu_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      func3,
    input  logic            inst_30,
    input  logic            inst_5,
    input  logic            inst_25,
    input  logic            op_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [3:0]      ALU_sel,
    output logic            type_IR,
    output logic            is_mext,
    output logic            md_stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    logic core_in_done;

    assign is_mext  = (ALUOp == 2'b10) & inst_5 & inst_25;
    assign md_stall = is_mext & op_valid & ~core_in_done;

    // base ALU decode; M-ops park the ALU on PASS
    always_comb begin
        ALU_sel = ALU_PASS;
        type_IR = ITYPE;
        unique case (ALUOp)
            2'b00: ALU_sel = ALU_ADD;
            2'b01: ALU_sel = ALU_SUB;
            2'b10: begin
                type_IR = inst_5 ? RTYPE : ITYPE;
                if (!is_mext) begin
                    unique case (func3)
                        3'b000:  ALU_sel = (inst_5 && inst_30) ? ALU_SUB : ALU_ADD;
                        3'b001:  ALU_sel = ALU_SLL;
                        3'b010:  ALU_sel = ALU_SLT;
                        3'b011:  ALU_sel = ALU_SLTU;
                        3'b100:  ALU_sel = ALU_XOR;
                        3'b101:  ALU_sel = inst_30 ? ALU_SRA : ALU_SRL;
                        3'b110:  ALU_sel = ALU_OR;
                        default: ALU_sel = ALU_AND;
                    endcase
                end
            end
            default: ;
        endcase
    end

    mdu_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mdu_core (
        .clk_i     (clk),
        .rst_ni    (rst),
        .start_i   (is_mext & op_valid & ~flush),
        .flush_i   (flush),
        .func3_i   (func3),
        .rs1_i     (rs1_val),
        .rs2_i     (rs2_val),
        .done_o    (md_done),
        .in_done_o (core_in_done),
        .result_o  (md_result)
    );

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Scoreboard bench for alu_mdu_ctrl (XLEN=32): decode checks, M-op results,
// latency/stall counts, fast paths, flush and async reset.
module tb_alu_mdu_ctrl;
    import alu_mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  ALUOp = '0;
    logic [2:0]  func3 = '0;
    logic        inst_30 = 1'b0, inst_5 = 1'b0, inst_25 = 1'b0;
    logic        op_valid = 1'b0, flush = 1'b0;
    logic [31:0] rs1_val = '0, rs2_val = '0;
    logic [3:0]  ALU_sel;
    logic        type_IR, is_mext, md_stall, md_done;
    logic [31:0] md_result;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] last_res = '0;

    alu_mdu_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .func3(func3), .inst_30(inst_30),
        .inst_5(inst_5), .inst_25(inst_25), .op_valid(op_valid), .flush(flush),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .ALU_sel(ALU_sel), .type_IR(type_IR),
        .is_mext(is_mext), .md_stall(md_stall), .md_done(md_done), .md_result(md_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference RV32M semantics in 64-bit arithmetic
    function automatic logic [31:0] mdu_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int mdu_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0) return 2;
            if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
            return 34;
        end
`ifdef MDU_FAST_MUL_EN
        return 3;
`else
        return 34;
`endif
    endfunction

    // issue one M-op, wait for md_done, score result, latency and stall length
    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int drop_at);
        int n, stall_cnt, lat;
        logic got_done;
        lat = mdu_lat(f3, a, b);
        exp_q.push_back(mdu_model(f3, a, b));
        lat_q.push_back(lat);
        @(negedge clk);
        ALUOp = 2'b10; inst_5 = 1'b1; inst_25 = 1'b1; inst_30 = 1'b0;
        func3 = f3; rs1_val = a; rs2_val = b; op_valid = 1'b1;
        n = 0; stall_cnt = 0; got_done = 1'b0;
        #1;
        if (md_stall) stall_cnt++;
        while (!got_done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (md_done) got_done = 1'b1;
            else if (md_stall) stall_cnt++;
            if (n == drop_at) op_valid = 1'b0;
        end
        chk($sformatf("done_seen f3=%0d", f3), 64'(got_done), 64'd1);
        if (got_done) begin
            chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), 64'(md_result), 64'(exp_q.pop_front()));
            chk($sformatf("latency f3=%0d", f3), 64'(n), 64'(lat_q.pop_front()));
            if (drop_at == 0) chk($sformatf("stall_cycles f3=%0d", f3), 64'(stall_cnt), 64'(lat));
            last_res = md_result;
        end else begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
        @(negedge clk);
        op_valid = 1'b0; inst_25 = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(md_done), 64'd0);
    endtask

    task automatic chk_dec(input string tag, input logic [1:0] op, input logic i5, input logic [2:0] f3,
                           input logic i30, input logic i25, input logic [3:0] exp_sel, input logic exp_t);
        ALUOp = op; inst_5 = i5; func3 = f3; inst_30 = i30; inst_25 = i25;
        #1;
        chk({tag, "_sel"}, 64'(ALU_sel), 64'(exp_sel));
        chk({tag, "_type"}, 64'(type_IR), 64'(exp_t));
    endtask

    initial begin
        int seen_done;
        #12;
        chk("rst_done", 64'(md_done), 64'd0);
        chk("rst_result", 64'(md_result), 64'd0);
        chk("rst_stall", 64'(md_stall), 64'd0);
        @(negedge clk); rst = 1'b1;

        // base decode (no M-op started: is_mext low or op_valid low)
        @(negedge clk);
        op_valid = 1'b1;
        chk_dec("dec_rsub", 2'b10, 1'b1, 3'b000, 1'b1, 1'b0, ALU_SUB, RTYPE);
        chk("dec_rsub_stall", 64'(md_stall), 64'd0);
        op_valid = 1'b0;
        chk_dec("dec_ld",   2'b00, 1'b0, 3'b010, 1'b0, 1'b0, ALU_ADD, ITYPE);
        chk_dec("dec_addi", 2'b10, 1'b0, 3'b000, 1'b1, 1'b0, ALU_ADD, ITYPE);
        chk_dec("dec_srai", 2'b10, 1'b0, 3'b101, 1'b1, 1'b0, ALU_SRA, ITYPE);
        chk_dec("dec_srl",  2'b10, 1'b1, 3'b101, 1'b0, 1'b0, ALU_SRL, RTYPE);
        chk_dec("dec_and",  2'b10, 1'b1, 3'b111, 1'b0, 1'b0, ALU_AND, RTYPE);
        chk_dec("dec_pass", 2'b11, 1'b0, 3'b000, 1'b0, 1'b0, ALU_PASS, ITYPE);
        chk_dec("dec_mext", 2'b10, 1'b1, 3'b100, 1'b0, 1'b1, ALU_PASS, RTYPE);
        chk("dec_mext_flag", 64'(is_mext), 64'd1);
        chk("dec_mext_stall_nv", 64'(md_stall), 64'd0);
        ALUOp = 2'b01; #1;
        chk("dec_beq_sel", 64'(ALU_sel), 64'(ALU_SUB));
        inst_25 = 1'b0; ALUOp = 2'b00;

        // multiply family
        run_mop(F3_MUL,    32'hFFFF_FFFD, 32'd7, 0);
        run_mop(F3_MULHU,  32'hFFFF_FFFD, 32'd7, 0);
        run_mop(F3_MULH,   32'hFFFF_FFFD, 32'd7, 0);
        run_mop(F3_MULHSU, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_mop(F3_MULH,   32'h8000_0000, 32'h8000_0000, 0);
        // divide fast paths
        run_mop(F3_DIV,    32'h0000_1234, 32'd0, 0);
        run_mop(F3_REMU,   32'h0000_1234, 32'd0, 0);
        run_mop(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_mop(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
        // iterative divide, signs and unsigned
        run_mop(F3_DIV,    32'hFFFF_FFF9, 32'd2, 0);
        run_mop(F3_DIV,    32'd7, 32'hFFFF_FFFE, 0);
        run_mop(F3_REM,    32'd7, 32'hFFFF_FFFE, 0);
        run_mop(F3_DIVU,   32'd100, 32'd7, 0);
        run_mop(F3_REMU,   32'd100, 32'd7, 3);   // op_valid drops mid-op

        // flush during a DIVU: no done, result held
        @(negedge clk);
        ALUOp = 2'b10; inst_5 = 1'b1; inst_25 = 1'b1; func3 = F3_DIVU;
        rs1_val = 32'd1000; rs2_val = 32'd3; op_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1; flush = 1'b1; op_valid = 1'b0;
        @(posedge clk); #1; flush = 1'b0; inst_25 = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md_done) seen_done++;
        end
        chk("flush_no_done", 64'(seen_done), 64'd0);
        chk("flush_hold_result", 64'(md_result), 64'(last_res));
        run_mop(F3_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run_mop(F3_MUL, 32'd5, 32'd6, 0);

        // async reset mid-CALC
        @(negedge clk);
        ALUOp = 2'b10; inst_5 = 1'b1; inst_25 = 1'b1; func3 = F3_MUL;
        rs1_val = 32'd9; rs2_val = 32'd9; op_valid = 1'b1;
        repeat (5) @(posedge clk);
        #2; rst = 1'b0; op_valid = 1'b0;
        #1;
        chk("midrst_done", 64'(md_done), 64'd0);
        chk("midrst_result", 64'(md_result), 64'd0);
        chk("midrst_stall", 64'(md_stall), 64'd0);
        @(negedge clk); rst = 1'b1; inst_25 = 1'b0;
        run_mop(F3_MUL, 32'd5, 32'd6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
